// File: rtl/led_scan_driver.sv
// HUB75 1/SCAN_ROWS-scan driver: fetches pixel pairs, shifts them out, latches, and shows each row.
// Define LED_SCAN_BRIGHT_EN to add a 3-bit bright input that trims the oe_n-low window inside SHOW.
module led_scan_driver #(
  parameter  int WIDTH     = 64,
  parameter  int SCAN_ROWS = 32,
  parameter  int ON_CYCLES = 64,
  localparam int XW        = $clog2(WIDTH),
  localparam int RW        = $clog2(SCAN_ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
`ifdef LED_SCAN_BRIGHT_EN
  input  logic [2:0]    bright,
`endif
  output logic [XW-1:0] rd_x,
  output logic [RW-1:0] rd_row,
  input  logic          rd_top,
  input  logic          rd_bot,
  output logic          r1,
  output logic          r2,
  output logic          panel_clk,
  output logic          lat,
  output logic          oe_n,
  output logic [RW-1:0] addr,
  output logic          frame_done
);

  localparam int CNT_MAX = (2 * WIDTH > ON_CYCLES) ? 2 * WIDTH : ON_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, BLANK, LATCH, SHOW} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d, next_row;
  logic [RW-1:0] rd_row_q, rd_row_d, addr_q, addr_d;
  logic [XW-1:0] rd_x_q, rd_x_d;
  logic          r1_q, r1_d, r2_q, r2_d;
  logic          pclk_q, pclk_d, lat_q, lat_d, oe_n_q, oe_n_d, fd_q, fd_d;
  logic          last_shift, last_show, load;
`ifdef LED_SCAN_BRIGHT_EN
  logic [CW:0]   lim_q, lim_d;
`endif

  assign last_shift = (cnt_q == CW'(2 * WIDTH - 1));
  assign last_show  = (cnt_q == CW'(ON_CYCLES - 1));
  assign next_row   = (row_q == RW'(SCAN_ROWS - 1)) ? '0 : row_q + 1'b1;
  // Pixel j is captured on entry to low phase 2j; FETCH supplies pixel 0.
  assign load = (state_q == FETCH) || (state_q == SHIFT && !last_shift && cnt_q[0]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    rd_row_d = rd_row_q;
    rd_x_d   = rd_x_q;
    addr_d   = addr_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    fd_d     = 1'b0;
    case (state_q)
      IDLE:  if (en) state_d = FETCH;
      FETCH: begin state_d = SHIFT; cnt_d = '0; end
      SHIFT: begin
        if (last_shift) begin
          state_d = BLANK;
          addr_d  = row_q;
          rd_x_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BLANK: state_d = LATCH;
      LATCH: begin state_d = SHOW; cnt_d = '0; end
      SHOW: begin
        if (last_show) begin
          state_d = en ? FETCH : IDLE;
          row_d   = next_row;
          fd_d    = (row_q == RW'(SCAN_ROWS - 1));
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      r1_d = rd_top;
      r2_d = rd_bot;
      if (rd_x_q != XW'(WIDTH - 1)) rd_x_d = rd_x_q + 1'b1;
    end
    // Present the next line's address during the last SHOW cycle so its
    // first pixel is already valid in FETCH.
    if (state_d == SHOW && cnt_d == CW'(ON_CYCLES - 1)) rd_row_d = next_row;
  end

`ifdef LED_SCAN_BRIGHT_EN
  always_comb begin
    lim_d = lim_q;
    if (state_q == LATCH) lim_d = (CW+1)'(((int'(bright) + 1) * ON_CYCLES) / 8);
  end
`endif

  always_comb begin
    pclk_d = (state_d == SHIFT) && cnt_d[0];
    lat_d  = (state_d == LATCH);
`ifdef LED_SCAN_BRIGHT_EN
    oe_n_d = !((state_d == SHOW) && ({1'b0, cnt_d} < lim_d));
`else
    oe_n_d = (state_d != SHOW);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      row_q    <= '0;
      rd_row_q <= '0;
      rd_x_q   <= '0;
      addr_q   <= '0;
      r1_q     <= 1'b0;
      r2_q     <= 1'b0;
      pclk_q   <= 1'b0;
      lat_q    <= 1'b0;
      oe_n_q   <= 1'b1;
      fd_q     <= 1'b0;
`ifdef LED_SCAN_BRIGHT_EN
      lim_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      rd_row_q <= rd_row_d;
      rd_x_q   <= rd_x_d;
      addr_q   <= addr_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      pclk_q   <= pclk_d;
      lat_q    <= lat_d;
      oe_n_q   <= oe_n_d;
      fd_q     <= fd_d;
`ifdef LED_SCAN_BRIGHT_EN
      lim_q    <= lim_d;
`endif
    end
  end

  assign rd_x       = rd_x_q;
  assign rd_row     = rd_row_q;
  assign r1         = r1_q;
  assign r2         = r2_q;
  assign panel_clk  = pclk_q;
  assign lat        = lat_q;
  assign oe_n       = oe_n_q;
  assign addr       = addr_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_led_scan_driver.sv
// Scoreboard bench for led_scan_driver: stimulus queues expected pixels/latch rows, a monitor checks panel events.
module tb_led_scan_driver;
  localparam int WIDTH     = 64;
  localparam int SCAN_ROWS = 32;
  localparam int ON_CYCLES = 64;
  localparam int ROW_P     = 2 * WIDTH + ON_CYCLES + 3;  // 195
  localparam int FRAME_P   = SCAN_ROWS * ROW_P;          // 6240
`ifdef LED_SCAN_BRIGHT_EN
  localparam int EXP_LOW   = 32;                         // bright=3: 4*64/8
`else
  localparam int EXP_LOW   = 64;
`endif

  logic       clk = 1'b0;
  logic       rst_n, en;
  logic [5:0] rd_x;
  logic [4:0] rd_row, addr;
  logic       rd_top, rd_bot, r1, r2, panel_clk, lat, oe_n, frame_done;
`ifdef LED_SCAN_BRIGHT_EN
  logic [2:0] bright = 3'd3;
`endif

  led_scan_driver #(.WIDTH(WIDTH), .SCAN_ROWS(SCAN_ROWS), .ON_CYCLES(ON_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
`ifdef LED_SCAN_BRIGHT_EN
    .bright(bright),
`endif
    .rd_x(rd_x), .rd_row(rd_row), .rd_top(rd_top), .rd_bot(rd_bot),
    .r1(r1), .r2(r2), .panel_clk(panel_clk), .lat(lat), .oe_n(oe_n),
    .addr(addr), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Directed image: (x=5,y=3), (x=10,y=40), full line 31, odd columns of y=52,
  // last column of y=0, first column of y=32.
  function automatic logic pix(input int y, input int x);
    if (y == 3  && x == 5)  return 1'b1;
    if (y == 40 && x == 10) return 1'b1;
    if (y == 31)            return 1'b1;
    if (y == 52)            return (x % 2) == 1;
    if (y == 0  && x == 63) return 1'b1;
    if (y == 32 && x == 0)  return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    rd_top <= pix(int'(rd_row), int'(rd_x));
    rd_bot <= pix(int'(rd_row) + SCAN_ROWS, int'(rd_x));
  end

  typedef struct {int row; int col; logic t; logic b;} px_t;
  px_t exp_px[$];
  int  exp_lat[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_count = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_row(input int r, input int n);
    px_t e;
    for (int c = 0; c < n; c++) begin
      e.row = r; e.col = c; e.t = pix(r, c); e.b = pix(r + SCAN_ROWS, c);
      exp_px.push_back(e);
    end
    if (n == WIDTH) exp_lat.push_back(r);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  px_t  p;
  logic pclk_p, r1_p, r2_p, oe_p, lat_p;
  logic [4:0] addr_p;
  int   rises, low_run, since_lat, last_lat, last_fd;
  always @(negedge clk) begin
    if (!rst_n) begin
      pclk_p = 0; r1_p = 0; r2_p = 0; oe_p = 1; lat_p = 0; addr_p = 0;
      rises = 0; low_run = 0; since_lat = 0; last_lat = -1; last_fd = -1;
    end else begin
      since_lat++;
      if (panel_clk && !pclk_p) begin
        if (exp_px.size() == 0) chk("px_queue_nonempty", 0, 1);
        else begin
          p = exp_px.pop_front();
          chk($sformatf("r1 row%0d col%0d", p.row, p.col), int'(r1), int'(p.t));
          chk($sformatf("r2 row%0d col%0d", p.row, p.col), int'(r2), int'(p.b));
          chk($sformatf("r1_stable row%0d col%0d", p.row, p.col), int'(r1), int'(r1_p));
          chk($sformatf("r2_stable row%0d col%0d", p.row, p.col), int'(r2), int'(r2_p));
        end
        rises++;
      end
      if (!oe_n) begin
        low_run++;
        chk("addr_stable_while_on", int'(addr), int'(addr_p));
      end
      if (oe_n && !oe_p) begin
        chk("oe_low_cycles", low_run, EXP_LOW);
        low_run = 0;
      end
      if (lat) begin
        if (exp_lat.size() == 0) chk("lat_queue_nonempty", 0, 1);
        else chk("lat_addr", int'(addr), exp_lat.pop_front());
        chk("oe_n_at_lat", int'(oe_n), 1);
        chk("lat_single_cycle", int'(lat_p), 0);
        chk("rises_per_row", rises, WIDTH);
        rises = 0;
        since_lat = 0;
        last_lat = int'(addr);
      end
      if (frame_done) begin
        chk("fd_after_last_row", last_lat, SCAN_ROWS - 1);
        chk("fd_delay_after_lat", since_lat, ON_CYCLES + 1);
        if (last_fd >= 0) chk("frame_period", cyc - last_fd, FRAME_P);
        last_fd = cyc;
        fd_count++;
      end
      pclk_p = panel_clk; r1_p = r1; r2_p = r2; oe_p = oe_n; lat_p = lat; addr_p = addr;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, " panel_clk"}, int'(panel_clk), 0);
    chk({tag, " lat"}, int'(lat), 0);
    chk({tag, " oe_n"}, int'(oe_n), 1);
    chk({tag, " r1"}, int'(r1), 0);
    chk({tag, " r2"}, int'(r2), 0);
    chk({tag, " addr"}, int'(addr), 0);
    chk({tag, " rd_x"}, int'(rd_x), 0);
    chk({tag, " rd_row"}, int'(rd_row), 0);
    chk({tag, " frame_done"}, int'(frame_done), 0);
  endtask

  task automatic first_rise(input string tag);
    int k;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (panel_clk) break;
    end
    chk(tag, k, 3);
  endtask

  task automatic wait_lat(input int a);
    int k;
    for (k = 0; k < 2 * FRAME_P; k++) begin
      @(negedge clk);
      if (lat && int'(addr) == a) break;
    end
    chk($sformatf("wait_lat_row%0d_in_time", a), int'(k < 2 * FRAME_P), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < SCAN_ROWS; r++) push_row(r, WIDTH);
    for (int r = 0; r < 7; r++) push_row(r, WIDTH);
    push_row(7, 20);
    repeat (3) @(negedge clk);
    check_reset("rst_hold");
    rst_n = 1'b1;
    first_rise("first_rise_after_reset");

    for (int k = 0; k < 2 * FRAME_P + 500 && fd_count < 2; k++) @(negedge clk);
    chk("two_frames_done", fd_count, 2);

    // Async reset in SHIFT cycle 40 of line 7 (20 columns already shifted).
    wait_lat(6);
    repeat (106) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_async_midrow");
    chk("px_queue_drained_at_reset", exp_px.size(), 0);
    chk("lat_queue_drained_at_reset", exp_lat.size(), 0);

    for (int r = 0; r <= 12; r++) push_row(r, WIDTH);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    first_rise("first_rise_after_midrow_reset");

    // Drop en in SHIFT cycle 20 of line 12.
    wait_lat(11);
    repeat (86) @(negedge clk);
    en = 1'b0;
    wait_lat(12);
    repeat (ON_CYCLES + 100) @(negedge clk);
    chk("idle_oe_n", int'(oe_n), 1);
    chk("idle_panel_clk", int'(panel_clk), 0);
    chk("idle_px_queue_empty", exp_px.size(), 0);

    push_row(13, WIDTH);
    en = 1'b1;
    first_rise("first_rise_after_en");
    repeat (5) @(negedge clk);
    en = 1'b0;
    wait_lat(13);
    repeat (ON_CYCLES + 20) @(negedge clk);
    chk("final_px_queue_empty", exp_px.size(), 0);
    chk("final_lat_queue_empty", exp_lat.size(), 0);
    chk("final_idle_oe_n", int'(oe_n), 1);
    chk("frame_done_total", fd_count, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout actual=%0d expected=finish", cyc);
    $fatal(1);
  end

endmodule

// File: doc/led_scan_driver.md
Name: led_scan_driver

Overview:
- Downstream of the frame/compose stage that builds the 64x64 monochrome pong image (ball, paddles, centre line, scores).
- Scans that image out to a HUB75-style 1/32-scan LED panel: two rows per scan line (top half and bottom half).
- Fetches pixels through a one-cycle-latency read port, shifts them out, latches, and enables the row for a fixed on-time.
- Paces rows with an internal FSM and flags frame completion.

Parameters:
- WIDTH, 64, panel columns per row.
- SCAN_ROWS, 32, scan lines; panel height = 2*SCAN_ROWS.
- ON_CYCLES, 64, clk cycles a latched row is displayed; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; sampled only at row boundaries.
- rd_x  out  clog2(WIDTH)  pixel read column.
- rd_row  out  clog2(SCAN_ROWS)  pixel read scan line.
- rd_top  in  1  pixel (rd_x, rd_row), valid one clk after the address is presented.
- rd_bot  in  1  pixel (rd_x, rd_row+SCAN_ROWS), same timing as rd_top.
- r1  out  1  panel top-half data.
- r2  out  1  panel bottom-half data.
- panel_clk  out  1  panel shift clock; idles low.
- lat  out  1  panel latch strobe, active high.
- oe_n  out  1  panel output enable, active low.
- addr  out  clog2(SCAN_ROWS)  panel row address.
- frame_done  out  1  one-cycle pulse at end of the last scan line.

Behaviour:
- Reset (async, any time, including mid-row):
  - panel_clk=0, lat=0, oe_n=1, r1=r2=0, addr=0, rd_x=0, rd_row=0, frame_done=0.
  - Row counter=0, state=IDLE.
- All panel outputs registered; no combinational path from rd_top/rd_bot to outputs.
- States and per-row sequence for scan line r:
  - IDLE: oe_n=1, panel_clk=0. Go to FETCH when en=1.
  - FETCH (1 cycle): rd_row=r, rd_x=0.
  - SHIFT (2*WIDTH cycles): panel_clk alternates low/high, starting low and ending high, giving exactly WIDTH rising edges.
    - At the i-th rising edge (i from 0), r1 = pixel(i,r) and r2 = pixel(i,r+SCAN_ROWS).
    - r1/r2 change only while panel_clk is low.
    - rd_x advances one column ahead of shifted data; no wrap past WIDTH-1 within a row.
  - BLANK (1 cycle): panel_clk=0, oe_n=1, addr<=r. addr changes only here or at reset.
  - LATCH (1 cycle): lat=1 for exactly this cycle, oe_n=1.
  - SHOW (ON_CYCLES cycles): oe_n=0, lat=0, panel_clk=0.
  - End of SHOW, if r==SCAN_ROWS-1: r wraps to 0 and frame_done=1 for one cycle (first cycle of the next state).
  - End of SHOW, otherwise: r=r+1.
  - Next state is FETCH if en=1, else IDLE.
- oe_n is low only in SHOW; never low while lat=1 or while addr changes.
- Row period: 2*WIDTH+ON_CYCLES+3 clk. Frame period: SCAN_ROWS times the row period.
- en rules:
  - Deasserting en mid-row does not abort; the row completes, including SHOW.
  - The driver then idles and resumes at the next scan line, not row 0.
  - frame_done still fires if the completed row was the last.
- Pixel data is not snapshotted; the upstream stage owns tearing avoidance. frame_done is the safe point to swap.

Optional Feature:
- Macro LED_SCAN_BRIGHT_EN.
- Defined:
  - Adds input bright (3 bits), sampled on entry to SHOW.
  - oe_n is low for the first floor((bright+1)*ON_CYCLES/8) SHOW cycles and high for the remainder.
  - SHOW length and row period are unchanged.
  - bright=7 equals full on; for ON_CYCLES>=8, bright=0 gives ON_CYCLES/8.
- Undefined: no bright port; oe_n low for all ON_CYCLES.

Test Plan:
- Reset: hold rst_n=0 with en=1 -> all outputs at reset values. Release -> first panel_clk rise 2 cycles after entering FETCH; 64 rises per row; lat pulses once per row.
- Single top pixel: only (5,3) set -> r1=1 solely at rising edge 5 of scan line 3; r2 always 0; addr=3 during that row's LATCH/SHOW.
- Single bottom pixel: only (10,40) set -> r2=1 solely at rising edge 10 of scan line 8; r1 always 0.
- Frame timing: en held high from IDLE -> frame_done pulses once every 32*(128+64+3)=6240 clk; addr sequence 0..31 then wraps to 0.
- en drop: deassert en at SHIFT cycle 20 of line 12 -> line 12 completes (SHOW 64 cycles), driver idles with oe_n=1. Reassert -> FETCH of line 13.
- Reset mid-SHIFT of line 7 -> outputs return to reset values immediately (async). After release with en=1 -> scan restarts at line 0. With LED_SCAN_BRIGHT_EN and bright=3 -> oe_n low exactly 32 cycles per SHOW.
